// File: rtl/led_matrix_fb_ctrl.sv
// led_matrix_fb_ctrl
// Double-buffered 8x8 RGB frame buffer that sits between two pixel producers
// and the row-scan PWM driver. Producers write only the back bank. The driver
// reads only the front bank. The banks swap only on frame_sync, so the driver
// never shows a torn frame. After each swap the new front can optionally be
// copied into the new back.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   reqN_valid/addr/data pixel write request N (addr = {row,col}, data = {R,G,B})
//   reqN_ready          write N accepted this cycle (combinational)
//   swap_req            pulse: swap the banks at the next frame boundary
//   frame_sync          pulse from the scan driver at end of frame
//   swap_pending        a swap has been captured but not yet performed
//   front_sel           bank currently displayed
//   busy                clearing or copying; writes are blocked
//   rd_addr/rd_data     front-bank read, 1-cycle latency
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_CLEAR   | zero both banks, one address per cycle, 64 cycles
// ST_RUN     | arbitrate pixel writes into the back bank
// ST_WAIT    | swap captured, waiting for frame_sync
// ST_COPY    | copy front bank into back bank, one address per cycle
module led_matrix_fb_ctrl #(
    parameter int CH_W         = 8,
    parameter bit COPY_ON_SWAP = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [5:0]          req0_addr,
    input  logic [3*CH_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [5:0]          req1_addr,
    input  logic [3*CH_W-1:0]   req1_data,
    output logic                req1_ready,
    input  logic                swap_req,
    input  logic                frame_sync,
    output logic                swap_pending,
    output logic                front_sel,
    output logic                busy,
    input  logic [5:0]          rd_addr,
    output logic [3*CH_W-1:0]   rd_data
);

    localparam int PW = 3 * CH_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_COPY  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [5:0]      r_cnt;
    logic            r_front_sel;
    logic            r_swap_pending;
    logic            r_rr_ptr;        // 0 favours requester 0
    logic [PW-1:0]   r_rd_data;
    logic [PW-1:0]   r_mem0 [64];
    logic [PW-1:0]   r_mem1 [64];

    logic            w_cnt_last;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_do_swap;
    logic            w_swap_cap;
    logic            w_clr_we;
    logic            w_back_we;
    logic [5:0]      w_wr_addr;
    logic [PW-1:0]   w_wr_data;
    logic [PW-1:0]   w_front_cpy;

    assign w_cnt_last  = (r_cnt == 6'd63);
    assign w_front_cpy = r_front_sel ? r_mem1[r_cnt] : r_mem0[r_cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_do_swap   = 1'b0;
        w_swap_cap  = 1'b0;
        w_clr_we    = 1'b0;
        w_back_we   = 1'b0;
        w_wr_addr   = r_cnt;
        w_wr_data   = '0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (w_cnt_last) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_gnt0 = req0_valid & (~req1_valid | ~r_rr_ptr);
                w_gnt1 = req1_valid & (~req0_valid |  r_rr_ptr);
                if (w_gnt0) begin
                    w_back_we = 1'b1;
                    w_wr_addr = req0_addr;
                    w_wr_data = req0_data;
                end else if (w_gnt1) begin
                    w_back_we = 1'b1;
                    w_wr_addr = req1_addr;
                    w_wr_data = req1_data;
                end
                // frame_sync in this cycle is deliberately not honoured;
                // the swap waits for the next frame boundary.
                if (swap_req) begin
                    w_swap_cap  = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (frame_sync) begin
                    w_do_swap   = 1'b1;
                    w_state_nxt = COPY_ON_SWAP ? ST_COPY : ST_RUN;
                end
            end
            ST_COPY: begin
                // front_sel has already toggled, so front/back are the new ones
                w_back_we = 1'b1;
                w_wr_data = w_front_cpy;
                if (swap_req) w_swap_cap = 1'b1;
                if (w_cnt_last) begin
                    w_state_nxt = (r_swap_pending | swap_req) ? ST_WAIT : ST_RUN;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= 6'd0;
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_rr_ptr       <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            // counter wraps 63 -> 0 so the next COPY/CLEAR pass starts at 0
            if (r_state == ST_CLEAR || r_state == ST_COPY) begin
                r_cnt <= r_cnt + 6'd1;
            end else begin
                r_cnt <= 6'd0;
            end
            if (w_do_swap) begin
                r_front_sel    <= ~r_front_sel;
                r_swap_pending <= 1'b0;
            end else if (w_swap_cap) begin
                r_swap_pending <= 1'b1;
            end
            if (w_gnt0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_gnt1) begin
                r_rr_ptr <= 1'b0;
            end
            if (r_state == ST_CLEAR) begin
                r_rd_data <= '0;
            end else begin
                r_rd_data <= r_front_sel ? r_mem1[rd_addr] : r_mem0[rd_addr];
            end
        end
    end

    // Storage carries no reset; CLEAR initialises it after every reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem0[r_cnt] <= '0;
                r_mem1[r_cnt] <= '0;
            end else if (w_back_we) begin
                if (r_front_sel) begin
                    r_mem0[w_wr_addr] <= w_wr_data;
                end else begin
                    r_mem1[w_wr_addr] <= w_wr_data;
                end
            end
        end
    end

    assign req0_ready   = w_gnt0;
    assign req1_ready   = w_gnt1;
    assign swap_pending = r_swap_pending;
    assign front_sel    = r_front_sel;
    assign busy         = (r_state == ST_CLEAR) || (r_state == ST_COPY);
    assign rd_data      = r_rd_data;

endmodule

// File: tb/tb_led_matrix_fb_ctrl.sv
// Directed bench for led_matrix_fb_ctrl (CH_W=8, COPY_ON_SWAP=1).
module tb_led_matrix_fb_ctrl;

    localparam int CH_W = 8;
    localparam int PW   = 3 * CH_W;

    logic          clk;
    logic          rst;
    logic          req0_valid;
    logic [5:0]    req0_addr;
    logic [PW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [5:0]    req1_addr;
    logic [PW-1:0] req1_data;
    logic          req1_ready;
    logic          swap_req;
    logic          frame_sync;
    logic          swap_pending;
    logic          front_sel;
    logic          busy;
    logic [5:0]    rd_addr;
    logic [PW-1:0] rd_data;

    int n_tests;
    int n_fail;

    led_matrix_fb_ctrl #(.CH_W(CH_W), .COPY_ON_SWAP(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .swap_req     (swap_req),
        .frame_sync   (frame_sync),
        .swap_pending (swap_pending),
        .front_sel    (front_sel),
        .busy         (busy),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        tick(); tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_tests++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL reset_front_sel: got %b expected 0", front_sel); end
        n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", swap_pending); end
        n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (busy !== 1'b1) bad++;
            tick();
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL clear_busy_len: got %0d low cycles expected 0", bad); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_done_busy: got %b expected 0", busy); end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            tick();
            if (rd_data !== '0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL clear_reads_zero: got %0d nonzero expected 0", bad); end
    endtask

    task automatic test_arbitration();
        req0_addr = 6'd5; req0_data = 24'hFF0000;
        req1_addr = 6'd9; req1_data = 24'h00FF00;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rd_addr = 6'd5; tick();
        n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL front5_before_swap: got %h expected 0", rd_data); end
        rd_addr = 6'd9; tick();
        n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL front9_before_swap: got %h expected 0", rd_data); end
    endtask

    task automatic test_swap();
        int bad;
        req0_addr = 6'd12; req0_data = 24'h123456; req0_valid = 1'b1; swap_req = 1'b1;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL write_with_swap_ready: got %b expected 1", req0_ready); end
        tick();
        req0_valid = 1'b0; swap_req = 1'b0;
        n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL swap_pending_set: got %b expected 1", swap_pending); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || swap_pending !== 1'b1) bad++;
            tick();
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wait_sync_hold: got %0d bad cycles expected 0", bad); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        frame_sync = 1'b1; #1;
        n_tests++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL front_before_sync: got %b expected 0", front_sel); end
        tick();
        frame_sync = 1'b0;
        n_tests++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL front_after_sync: got %b expected 1", front_sel); end
        n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL pending_after_sync: got %b expected 0", swap_pending); end
    endtask

    task automatic test_copy();
        int bad;
        // just past the toggle edge: COPY has begun
        rd_addr = 6'd12;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (busy !== 1'b1) bad++;
            tick();
            if (i == 0) begin
                n_tests++; if (rd_data !== 24'h123456) begin n_fail++; $display("FAIL swapped_read12: got %h expected 123456", rd_data); end
            end
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL copy_busy_len: got %0d low cycles expected 0", bad); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL copy_done_busy: got %b expected 0", busy); end

        req1_addr = 6'd0; req1_data = 24'hABCDEF; req1_valid = 1'b1; #1;
        n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL lone_req1_ready: got %b expected 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        n_tests++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL second_swap_front: got %b expected 0", front_sel); end
        rd_addr = 6'd12; tick();
        n_tests++; if (rd_data !== 24'h123456) begin n_fail++; $display("FAIL copied_read12: got %h expected 123456", rd_data); end
        rd_addr = 6'd0; tick();
        n_tests++; if (rd_data !== 24'hABCDEF) begin n_fail++; $display("FAIL new_read0: got %h expected abcdef", rd_data); end
        rd_addr = 6'd5; tick();
        n_tests++; if (rd_data !== 24'hFF0000) begin n_fail++; $display("FAIL copied_read5: got %h expected ff0000", rd_data); end
        rd_addr = 6'd9; tick();
        n_tests++; if (rd_data !== 24'h00FF00) begin n_fail++; $display("FAIL copied_read9: got %h expected 00ff00", rd_data); end
        for (int i = 4; i < 64; i++) begin
            if (i == 10) swap_req = 1'b1;
            tick();
            swap_req = 1'b0;
            if (i == 10) begin
                n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL copy_swap_capture: got %b expected 1", swap_pending); end
            end
        end
        req0_valid = 1'b1; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL copy_to_wait_busy: got %b expected 0", busy); end
        n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL copy_to_wait_pending: got %b expected 1", swap_pending); end
        n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL copy_to_wait_ready: got %b expected 0", req0_ready); end
        req0_valid = 1'b0;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        n_tests++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL third_swap_front: got %b expected 1", front_sel); end
        for (int i = 0; i < 64; i++) tick();
    endtask

    task automatic test_collision();
        swap_req = 1'b1; frame_sync = 1'b1; tick();
        swap_req = 1'b0; frame_sync = 1'b0;
        n_tests++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL coincident_no_toggle: got %b expected 1", front_sel); end
        n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL coincident_pending: got %b expected 1", swap_pending); end
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        tick(); tick(); tick();
        n_tests++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL second_req_no_toggle: got %b expected 1", front_sel); end
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        n_tests++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL collision_toggle: got %b expected 0", front_sel); end
        for (int i = 0; i < 64; i++) tick();
        n_tests++; if ({front_sel, swap_pending, busy} !== 3'b000) begin n_fail++; $display("FAIL single_toggle_state: got %b expected 000", {front_sel, swap_pending, busy}); end
    endtask

    task automatic test_reset_mid_copy();
        int bad;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        n_tests++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL pre_reset_front: got %b expected 1", front_sel); end
        for (int i = 0; i < 30; i++) begin
            if (i == 5) frame_sync = 1'b1;
            if (i == 10) swap_req = 1'b1;
            tick();
            frame_sync = 1'b0; swap_req = 1'b0;
            if (i == 5) begin
                n_tests++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL sync_ignored_in_copy: got %b expected 1", front_sel); end
            end
            if (i == 10) begin
                n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pending: got %b expected 1", swap_pending); end
            end
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midcopy_reset_busy: got %b expected 1", busy); end
        n_tests++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL midcopy_reset_front: got %b expected 0", front_sel); end
        n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL midcopy_reset_pending: got %b expected 0", swap_pending); end
        for (int i = 0; i < 64; i++) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reclear_busy: got %b expected 0", busy); end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            tick();
            if (rd_data !== '0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL reclear_reads_zero: got %0d nonzero expected 0", bad); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        swap_req = 1'b0; frame_sync = 1'b0; rd_addr = '0;
        test_reset();
        test_arbitration();
        test_swap();
        test_copy();
        test_collision();
        test_reset_mid_copy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
